// File: rtl/seq_divider.sv
// Restoring shift-and-subtract divider: one quotient bit per clock, with signed/unsigned
// quotient and remainder and a fixed 33-cycle latency from accept to done.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic sgn, input logic [WIDTH-1:0] v);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_negate(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   dvd_raw_q, dvd_raw_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;

  // The stored remainder is always below the divisor, so its top bit of the
  // WIDTH+1-bit working value only exists transiently in rem_shift/trial.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    q_d         = q_q;
    dvsr_d      = dvsr_q;
    dvd_raw_d   = dvd_raw_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    rem_shift   = {rem_q, q_q[WIDTH-1]};
    trial       = rem_shift - {1'b0, dvsr_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          dvd_raw_d = dividend;
          dvsr_d    = magnitude(is_signed, divisor);
          q_d       = magnitude(is_signed, dividend);
          neg_q_d   = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r_d   = is_signed & dividend[WIDTH-1];
          rem_d     = '0;
          cnt_d     = '0;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        // A zero divisor still ran all steps; its result is replaced here.
        if (dvsr_q == '0) begin
          quotient_d  = '1;
          remainder_d = dvd_raw_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = cond_negate(neg_q_q, q_q);
          remainder_d = cond_negate(neg_r_q, rem_q);
          dbz_d       = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q     <= cnt_d;
    rem_q     <= rem_d;
    q_q       <= q_d;
    dvsr_q    <= dvsr_d;
    dvd_raw_q <= dvd_raw_d;
    neg_q_q   <= neg_q_d;
    neg_r_q   <= neg_r_d;
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors, handshake and reset
// scenarios, and randomized operations against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] obs_q, obs_r;
  logic        obs_z;
  int          lat, bcnt;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division; signed uses 64-bit truncating division.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; z = 1'b0;
    end else begin
      lq = sa / sb; lr = sa % sb;
      q = lq[31:0]; r = lr[31:0]; z = 1'b0;
    end
  endfunction

  // Drive one operation and wait (bounded) for done; latency counted in edges after accept.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    obs_q = quotient; obs_r = remainder; obs_z = div_by_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_quot got=%h want=0", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_rem got=%h want=0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] da [9] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'd5, 32'd5, 32'd9,
                            32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] db [9] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd3,
                            32'hFFFF_FFFF, 32'd1, 32'h8000_0000};
    logic        ds [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] eq [9] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] er [9] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0,
                            32'h7FFF_FFFF};
    logic        ez [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      do_op(da[i], db[i], ds[i]);
      n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL dir%0d_latency got=%0d want=33", i, lat); end
      n_cmp++; if (bcnt != 33) begin n_fail++; $display("FAIL dir%0d_busy_cycles got=%0d want=33", i, bcnt); end
      n_cmp++; if (obs_q !== eq[i]) begin n_fail++; $display("FAIL dir%0d_quot got=%h want=%h", i, obs_q, eq[i]); end
      n_cmp++; if (obs_r !== er[i]) begin n_fail++; $display("FAIL dir%0d_rem got=%h want=%h", i, obs_r, er[i]); end
      n_cmp++; if (obs_z !== ez[i]) begin n_fail++; $display("FAIL dir%0d_dbz got=%b want=%b", i, obs_z, ez[i]); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_at_done got=%b want=0", i, busy); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width got=%b want=0", i, done); end
      n_cmp++; if (quotient !== eq[i]) begin n_fail++; $display("FAIL dir%0d_quot_hold got=%h want=%h", i, quotient, eq[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, wq, wr;
    logic        s, wz;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; s = 1'($urandom);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 15);
        4: begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      ref_div(a, b, s, wq, wr, wz);
      do_op(a, b, s);
      n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d want=33", i, lat); end
      n_cmp++; if (obs_q !== wq) begin n_fail++; $display("FAIL rnd%0d_quot a=%h b=%h s=%b got=%h want=%h", i, a, b, s, obs_q, wq); end
      n_cmp++; if (obs_r !== wr) begin n_fail++; $display("FAIL rnd%0d_rem a=%h b=%h s=%b got=%h want=%h", i, a, b, s, obs_r, wr); end
      n_cmp++; if (obs_z !== wz) begin n_fail++; $display("FAIL rnd%0d_dbz got=%b want=%b", i, obs_z, wz); end
    end
  endtask

  task automatic test_ignore_busy();
    dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    dividend = 32'd7; divisor = 32'd7; is_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 10;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL ignore_latency got=%0d want=33", lat); end
    n_cmp++; if (quotient !== 32'd10) begin n_fail++; $display("FAIL ignore_quot got=%h want=0000000a", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL ignore_rem got=%h want=0", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, q1, r1, q2, r2;
    logic        z1, z2;
    a1 = $urandom; b1 = $urandom_range(1, 1000);
    a2 = $urandom; b2 = $urandom_range(1, 100000);
    ref_div(a1, b1, 1'b0, q1, r1, z1);
    ref_div(a2, b2, 1'b1, q2, r2, z2);
    dividend = a1; divisor = b1; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    dividend = a2; divisor = b2; is_signed = 1'b1;
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL b2b_first_latency got=%0d want=33", lat); end
    n_cmp++; if (quotient !== q1) begin n_fail++; $display("FAIL b2b_first_quot got=%h want=%h", quotient, q1); end
    n_cmp++; if (remainder !== r1) begin n_fail++; $display("FAIL b2b_first_rem got=%h want=%h", remainder, r1); end
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept got=%b want=1", busy); end
    n_cmp++; if (quotient !== q1) begin n_fail++; $display("FAIL b2b_quot_held got=%h want=%h", quotient, q1); end
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL b2b_second_latency got=%0d want=33", lat); end
    n_cmp++; if (quotient !== q2) begin n_fail++; $display("FAIL b2b_second_quot got=%h want=%h", quotient, q2); end
    n_cmp++; if (remainder !== r2) begin n_fail++; $display("FAIL b2b_second_rem got=%h want=%h", remainder, r2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int saw_done;
    dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got=%b want=0", done); end
    n_cmp++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL rstmid_quot got=%h want=0", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL rstmid_rem got=%h want=0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rstmid_dbz got=%b want=0", div_by_zero); end
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) saw_done++;
    end
    n_cmp++; if (saw_done != 0) begin n_fail++; $display("FAIL rstmid_no_done got=%0d want=0", saw_done); end
    reset = 1'b1; start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_with_start_busy got=%b want=0", busy); end
    do_op(32'd1000, 32'd3, 1'b0);
    n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL rstmid_fresh_latency got=%0d want=33", lat); end
    n_cmp++; if (obs_q !== 32'd333) begin n_fail++; $display("FAIL rstmid_fresh_quot got=%h want=%h", obs_q, 32'd333); end
    n_cmp++; if (obs_r !== 32'd1) begin n_fail++; $display("FAIL rstmid_fresh_rem got=%h want=1", obs_r); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle 32-bit integer divider for the ALU. It performs the inverse of the ripple-carry add path: restoring division by shift-and-subtract, one quotient bit per clock. It produces quotient and remainder for signed (DIV/REM) and unsigned (DIVU/REMU) operations. It sits beside the combinational adder, and the control unit drives it through a start/busy/done handshake.

## Interface
- WIDTH, 32, operand and result width; all arithmetic below is stated for WIDTH=32.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- start  input  1  request; accepted only when busy=0.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- dividend  input  WIDTH  captured on accepting edge.
- divisor  input  WIDTH  captured on accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  result; held until next completion or reset.
- remainder  output  WIDTH  result; held until next completion or reset.
- div_by_zero  output  1  set with done when divisor was 0; held with results.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: busy=0. On start=1, the block:
  - latches operands and is_signed;
  - forms magnitudes |dividend| and |divisor| when is_signed=1, raw values otherwise;
  - records neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend), both 0 when unsigned;
  - clears the WIDTH+1-bit partial remainder;
  - loads the quotient shift register with the dividend magnitude;
  - clears the iteration counter (6 bits);
  - moves to CALC.
- CALC, one step per cycle, WIDTH steps:
  - shift {rem, q} left by one;
  - trial = rem_shifted − divisor_mag, computed in WIDTH+1 bits;
  - if trial is non-negative (no borrow): rem = trial and q[0] = 1; otherwise keep rem_shifted and set q[0] = 0;
  - after the step with counter = WIDTH−1, go to FIX.
- FIX, one cycle. Writes quotient, remainder and div_by_zero, pulses done, then returns to IDLE.
  - quotient = neg_q ? −q : q (two's complement, WIDTH bits).
  - remainder = neg_r ? −rem[WIDTH−1:0] : rem[WIDTH−1:0].
- Divide by zero: iterations still run, giving fixed latency. FIX overrides the results with quotient = 0xFFFFFFFF, remainder = the raw captured dividend, and div_by_zero = 1. Otherwise div_by_zero = 0.
- Signed overflow (0x80000000 / 0xFFFFFFFF): needs no special case. Magnitude math gives q = 0x80000000, and negation leaves it at 0x80000000. Remainder = 0. div_by_zero = 0.
- Dividend magnitude 0x80000000 is handled as unsigned 2^31; magnitude registers are WIDTH bits, unsigned.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; state=IDLE.
- start accepted on edge E0 (busy=0, start=1). busy=1 from after E0 through the cycle before done.
- CALC steps occur on edges E1..E32. FIX writes outputs on E33.
- After E33, done=1 for exactly one cycle and busy=0 in that same cycle. Latency from the accepting edge to done visible is 33 cycles; fixed for all operands.
- start while busy=1 is ignored; operands and state are not disturbed.
- start asserted during the done cycle is accepted (busy=0), and the next operation begins. Outputs keep prior results until the new FIX.
- Operand inputs are don't-care except on the accepting edge.
- reset=1 on any edge, including mid-CALC or in the same edge as start, forces reset values. The in-flight operation is discarded and start is not accepted on that edge.

## Test plan
- Unsigned 100 / 7, is_signed=0 -> done exactly 33 cycles after the accepting edge; quotient=14, remainder=2, div_by_zero=0; busy high for 33 cycles.
- Signed −100 / 7 (0xFFFFFF9C / 0x00000007) -> quotient=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2). Signed 100 / −7 -> quotient=0xFFFFFFF2, remainder=2.
- Divide by zero: 5 / 0, both signed and unsigned -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. Then 9 / 3 -> quotient=3, remainder=0, div_by_zero=0.
- Overflow and extremes:
  - signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0;
  - unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0;
  - unsigned 0xFFFFFFFF / 0x80000000 -> quotient=1, remainder=0x7FFFFFFF.
- Handshake:
  - start 50/5, then pulse start with 7/7 at cycle 10 of busy -> ignored, result quotient=10, remainder=0;
  - start held high through the done cycle -> second operation accepted and completes 33 cycles later.
- Reset mid-operation: start 1000/3, assert reset at busy cycle 15 -> next cycle all outputs 0, busy=0, no done pulse. A fresh 1000/3 after reset -> quotient=333, remainder=1.
